// File: rtl/bp_mem_cmd_arbiter_if.sv
// ============================================================================
// Module   : bp_mem_cmd_arbiter_if
// Purpose  : Requester-side and memory-side command/response bundle for the
//            memory command arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bp_mem_cmd_arbiter_if #(
    parameter int num_req_p   = 2,
    parameter int msg_width_p = 64
);
    logic [num_req_p*msg_width_p-1:0] mem_cmd_i;
    logic [num_req_p-1:0]             mem_cmd_v_i;
    logic [num_req_p-1:0]             mem_cmd_ready_o;
    logic [msg_width_p-1:0]           mem_cmd_o;
    logic                             mem_cmd_v_o;
    logic                             mem_cmd_ready_i;
    logic [msg_width_p-1:0]           mem_resp_i;
    logic                             mem_resp_v_i;
    logic                             mem_resp_yumi_o;
    logic [msg_width_p-1:0]           mem_resp_o;
    logic [num_req_p-1:0]             mem_resp_v_o;
    logic [num_req_p-1:0]             mem_resp_yumi_i;
    logic                             err_o;

    // The arbiter itself sits on the slave side of this bundle.
    modport slave (
        input  mem_cmd_i, mem_cmd_v_i, mem_cmd_ready_i,
               mem_resp_i, mem_resp_v_i, mem_resp_yumi_i,
        output mem_cmd_ready_o, mem_cmd_o, mem_cmd_v_o,
               mem_resp_yumi_o, mem_resp_o, mem_resp_v_o, err_o
    );

    modport master (
        output mem_cmd_i, mem_cmd_v_i, mem_cmd_ready_i,
               mem_resp_i, mem_resp_v_i, mem_resp_yumi_i,
        input  mem_cmd_ready_o, mem_cmd_o, mem_cmd_v_o,
               mem_resp_yumi_o, mem_resp_o, mem_resp_v_o, err_o
    );
endinterface

`default_nettype wire

// File: rtl/bp_mem_cmd_arbiter.sv
// ============================================================================
// Module   : bp_mem_cmd_arbiter
// Purpose  : Round-robin sharing of one memory command/response channel with
//            in-order response steering via an ID tracker FIFO.
//            Define BP_MEM_ARB_FIXED_PRIO_EN for lowest-index fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bp_mem_cmd_arbiter #(
    parameter int num_req_p     = 2,
    parameter int msg_width_p   = 64,
    parameter int outstanding_p = 4
) (
    input wire                  clk_i,
    input wire                  reset_n_i,
    bp_mem_cmd_arbiter_if.slave bus
);
    localparam int lg_req_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;
    localparam int lg_out_lp = (outstanding_p > 1) ? $clog2(outstanding_p) : 1;
    localparam int cnt_w_lp  = $clog2(outstanding_p + 1);

    logic [msg_width_p-1:0] cmd_q;
    logic                   cmd_v_q;
    logic [cnt_w_lp-1:0]    count_q;
    logic [lg_out_lp-1:0]   wptr_q;
    logic [lg_out_lp-1:0]   rptr_q;
    logic                   err_q;
    logic [lg_req_lp-1:0]   ids_q [outstanding_p];
`ifndef BP_MEM_ARB_FIXED_PRIO_EN
    logic [lg_req_lp-1:0]   last_q;
`endif

    logic [lg_req_lp-1:0] grant_id;
    logic                 any_v;
    logic                 tracker_full;
    logic                 can_accept;
    logic                 accept;
    logic                 drain;
    logic [lg_req_lp-1:0] head_id;
    logic                 have_entry;
    logic                 resp_v_eff;
    logic                 pop;
    logic                 orphan;

    function automatic logic [lg_out_lp-1:0] ptr_inc(input logic [lg_out_lp-1:0] p);
        return (p == lg_out_lp'(outstanding_p - 1)) ? '0 : p + 1'b1;
    endfunction

    // Descending loop so the lowest search offset is the final assignment.
    always_comb begin
        grant_id = '0;
        any_v    = 1'b0;
`ifdef BP_MEM_ARB_FIXED_PRIO_EN
        for (int i = num_req_p - 1; i >= 0; i--) begin
            if (bus.mem_cmd_v_i[i]) begin
                grant_id = lg_req_lp'(i);
                any_v    = 1'b1;
            end
        end
`else
        for (int off = num_req_p; off >= 1; off--) begin
            if (bus.mem_cmd_v_i[(int'(last_q) + off) % num_req_p]) begin
                grant_id = lg_req_lp'((int'(last_q) + off) % num_req_p);
                any_v    = 1'b1;
            end
        end
`endif
    end

    assign tracker_full = (count_q == cnt_w_lp'(outstanding_p));
    assign can_accept   = (~cmd_v_q | bus.mem_cmd_ready_i) & ~tracker_full;
    assign accept       = any_v & can_accept & reset_n_i;
    assign drain        = cmd_v_q & bus.mem_cmd_ready_i;

    assign head_id    = ids_q[rptr_q];
    assign have_entry = (count_q != '0);
    assign resp_v_eff = bus.mem_resp_v_i & reset_n_i;
    assign pop        = resp_v_eff & have_entry & bus.mem_resp_yumi_i[head_id];
    assign orphan     = resp_v_eff & ~have_entry;

    assign bus.mem_cmd_ready_o = accept ? (num_req_p'(1) << grant_id) : '0;
    assign bus.mem_cmd_o       = reset_n_i ? cmd_q : '0;
    assign bus.mem_cmd_v_o     = cmd_v_q & reset_n_i;
    assign bus.mem_resp_o      = reset_n_i ? bus.mem_resp_i : '0;
    assign bus.mem_resp_v_o    = (resp_v_eff & have_entry) ? (num_req_p'(1) << head_id) : '0;
    assign bus.mem_resp_yumi_o = pop | orphan;
    assign bus.err_o           = err_q & reset_n_i;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            cmd_q   <= '0;
            cmd_v_q <= 1'b0;
            count_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            err_q   <= 1'b0;
`ifndef BP_MEM_ARB_FIXED_PRIO_EN
            last_q  <= lg_req_lp'(num_req_p - 1);
`endif
        end else begin
            if (accept) begin
                cmd_q   <= bus.mem_cmd_i[grant_id*msg_width_p +: msg_width_p];
                cmd_v_q <= 1'b1;
                wptr_q  <= ptr_inc(wptr_q);
`ifndef BP_MEM_ARB_FIXED_PRIO_EN
                last_q  <= grant_id;
`endif
            end else if (drain) begin
                cmd_v_q <= 1'b0;
            end
            if (pop) begin
                rptr_q <= ptr_inc(rptr_q);
            end
            if (accept && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (!accept && pop) begin
                count_q <= count_q - 1'b1;
            end
            if (orphan) begin
                err_q <= 1'b1;
            end
        end
    end

    // ID storage needs no reset: an entry is only read once count covers it.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            ids_q[wptr_q] <= grant_id;
        end
    end

endmodule

`default_nettype wire

// File: doc/bp_mem_cmd_arbiter.md
# bp_mem_cmd_arbiter

Shares one memory command/response channel among `num_req_p` cache engines, e.g. the I$ and D$ UCEs of a single-core tile. Command arbitration is round-robin. Each command passes through a one-entry output register. Responses return in order and are steered back to the requester that issued the matching command, using an in-order ID tracker FIFO. The block sits between the UCE `mem_cmd`/`mem_resp` ports and the tile memory port.

## Interface
Parameters:
- `num_req_p`, 2: number of requesters; must be ≥ 2.
- `msg_width_p`, `cce_mem_msg_width_lp`: width of a command or response message.
- `outstanding_p`, 4: capacity of the ID tracker, i.e. the maximum number of commands in flight; must be ≥ 1.
- `lg_req_lp` (localparam): `` `BSG_SAFE_CLOG2(num_req_p) ``.

Ports:
- `clk_i`, in, 1: clock.
- `reset_n_i`, in, 1: reset, synchronous, active-low.
- `mem_cmd_i`, in, `num_req_p*msg_width_p`: per-requester command.
- `mem_cmd_v_i`, in, `num_req_p`: per-requester command valid.
- `mem_cmd_ready_o`, out, `num_req_p`: per-requester accept (valid/ready; accepted = `v & ready`).
- `mem_cmd_o`, out, `msg_width_p`: command to memory.
- `mem_cmd_v_o`, out, 1: command valid to memory.
- `mem_cmd_ready_i`, in, 1: memory accepts the command.
- `mem_resp_i`, in, `msg_width_p`: response from memory.
- `mem_resp_v_i`, in, 1: response valid.
- `mem_resp_yumi_o`, out, 1: response consumed.
- `mem_resp_o`, out, `msg_width_p`: response broadcast to all requesters.
- `mem_resp_v_o`, out, `num_req_p`: one-hot response valid, for the routed requester only.
- `mem_resp_yumi_i`, in, `num_req_p`: per-requester consume.
- `err_o`, out, 1: sticky flag; set by a response that arrives while no command is outstanding.

## Operation
- **Command register.** One entry holding `cmd_r`, `cmd_v_r`. `mem_cmd_o = cmd_r`, `mem_cmd_v_o = cmd_v_r`.
- **Accept condition.** `can_accept = (~cmd_v_r | mem_cmd_ready_i) & ~tracker_full`. `mem_cmd_ready_o[g]` is asserted only for the granted requester, and only when `can_accept` holds.
- **Arbitration.** Round-robin over the requesters with `mem_cmd_v_i` set. The search starts at `last_r + 1` and wraps modulo `num_req_p`. `last_r` updates to the winner only on an accept.
- **Grant timing.** Grant is combinational within the cycle; the requester does not hold a grant across cycles.
- **On accept.**
  - `cmd_r ← mem_cmd_i[g]`, `cmd_v_r ← 1`.
  - Push `g` into the tracker.
- **On drain without a new accept.** `cmd_v_r ← 0`.
- **Tracker.** Circular FIFO of `lg_req_lp`-bit IDs with depth `outstanding_p`. It uses read/write pointers that wrap at `outstanding_p`, which need not be a power of two, plus a count of `$clog2(outstanding_p+1)` bits. `tracker_full = (count == outstanding_p)`.
- **Full tracker.** There is no same-cycle push/pop bypass: when the tracker is full, a response pop does not allow an accept in the same cycle.
- **Response routing.** `h` = head ID.
  - `mem_resp_v_o[h] = mem_resp_v_i & (count != 0)`.
  - `mem_resp_yumi_o = mem_resp_v_i & (count != 0) & mem_resp_yumi_i[h]`.
  - The tracker pops on `mem_resp_yumi_o`.
  - `mem_resp_yumi_i` bits other than `h` are ignored.
- **Orphan response.** If `mem_resp_v_i & (count == 0)`: no `mem_resp_v_o` bit is raised, `mem_resp_yumi_o = 1` (the response is dropped), and `err_o ← 1`.
- **Simultaneous push and pop.** Count is unchanged; both pointers advance.
- **Reset values.**
  - `cmd_v_r = 0`, `count = 0`, pointers = 0, `err_o = 0`.
  - `last_r = num_req_p-1`, so requester 0 wins first.
  - Every output is 0 during reset: `mem_cmd_ready_o`, `mem_resp_v_o` and `mem_resp_yumi_o` are forced low.
- **Reset mid-operation.** The buffered command and all tracker state are discarded. Responses that arrive after reset are orphans and set `err_o`.

## Timing
- **Command latency.** A command accepted in cycle N appears on `mem_cmd_v_o` in N+1.
- **Command throughput.** One command per cycle while `mem_cmd_ready_i` stays high.
- **Combinational paths.**
  - `mem_cmd_ready_o` depends combinationally on `mem_cmd_ready_i` and `mem_cmd_v_i`.
  - The response path is fully combinational: `mem_resp_i` passes to `mem_resp_o`, and `mem_resp_yumi_i` drives `mem_resp_yumi_o`, with zero latency.
- **Holding rule.** `mem_cmd_o` holds stable while `mem_cmd_v_o & ~mem_cmd_ready_i`.

## Configuration
- **`BP_MEM_ARB_FIXED_PRIO_EN` defined.**
  - Fixed priority: the lowest-index requester always wins.
  - `last_r` is not implemented.
- **Undefined (default).** Round-robin as above.

## Test plan
- **Reset.**
  - Stimulus: hold `reset_n_i=0` for 3 cycles with all inputs active.
  - Required: all outputs 0.
  - Release, then req0 valid with cmd `0xA5`: req0 is accepted in the first cycle; `mem_cmd_o=0xA5` and `mem_cmd_v_o=1` in the next cycle.
- **Contention.**
  - Stimulus: both requesters valid continuously; `mem_cmd_ready_i=1`; memory responds in order.
  - Required: grants alternate 0,1,0,1.
  - Required: each response is delivered only on the matching `mem_resp_v_o` bit, 4 of each.
- **Backpressure.**
  - Stimulus: `mem_cmd_ready_i=0` for 5 cycles.
  - Required: `mem_cmd_o` is stable, and no second accept occurs.
  - Required: on release, the next command is accepted in the same cycle as the drain.
- **Tracker full.**
  - Stimulus: issue 4 commands with no responses (`outstanding_p=4`).
  - Required: `mem_cmd_ready_o=0`.
  - Stimulus: one response consumed.
  - Required: accept resumes in the following cycle, not the same cycle.
- **Requester stall.**
  - Stimulus: head ID = 1 and `mem_resp_yumi_i[1]=0` for 3 cycles.
  - Required: `mem_resp_yumi_o=0` and `mem_resp_v_o=2'b10` held for those cycles.
- **Orphan.**
  - Stimulus: a response arrives with the tracker empty.
  - Required: `mem_resp_yumi_o=1`, `mem_resp_v_o=0`, and `err_o=1` from the next cycle until reset.
